// File: rtl/sched_assign_ctrl.sv
// Timed per-target commit of a|b into q[t]. Operands are sampled at accept (mode 0) or at expiry (mode 1).
// Latency: an accept at edge k commits q[t] at edge k+1+req_dly; done[t] is high for the cycle after the commit edge.
// Backpressure: req_ready = ~busy[req_tgt]; flush cancels every pending slot and drops any same-cycle accept.
module sched_assign_ctrl #(
  parameter  int N_TGT = 4,
  parameter  int DLY_W = 6,
  localparam int TGT_W = $clog2(N_TGT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TGT_W-1:0] req_tgt,
  input  logic [DLY_W-1:0] req_dly,
  input  logic             req_mode,
  input  logic             flush,
  output logic [N_TGT-1:0] q,
  output logic [N_TGT-1:0] busy,
  output logic [N_TGT-1:0] done
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} slot_state_t;

  slot_state_t      state_q [N_TGT];
  slot_state_t      state_d [N_TGT];
  logic [DLY_W-1:0] cnt_q   [N_TGT];
  logic [DLY_W-1:0] cnt_d   [N_TGT];
  logic [N_TGT-1:0] mode_q, mode_d;
  logic [N_TGT-1:0] hold_q, hold_d;
  logic [N_TGT-1:0] q_d, done_d;
  logic             ab;
  logic             accept;

  assign ab        = a | b;
  assign req_ready = ~busy[req_tgt];
  // Flush has priority over a request arriving in the same cycle.
  assign accept    = req_valid & req_ready & ~flush;

  // busy is a direct view of the registered slot state.
  always_comb begin
    busy = '0;
    for (int t = 0; t < N_TGT; t++) begin
      busy[t] = (state_q[t] == S_WAIT);
    end
  end

  // Per-slot next state: load on accept, count down, then commit once cnt reaches zero.
  always_comb begin
    for (int t = 0; t < N_TGT; t++) begin
      state_d[t] = state_q[t];
      cnt_d[t]   = cnt_q[t];
    end
    mode_d = mode_q;
    hold_d = hold_q;
    q_d    = q;
    done_d = '0;
    for (int t = 0; t < N_TGT; t++) begin
      case (state_q[t])
        S_IDLE: begin
          if (accept && (req_tgt == TGT_W'(t))) begin
            state_d[t] = S_WAIT;
            cnt_d[t]   = req_dly;
            mode_d[t]  = req_mode;
            // Only the sample-at-accept mode captures the operands now.
            hold_d[t]  = req_mode ? hold_q[t] : ab;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state_d[t] = S_IDLE;
          end else if (cnt_q[t] != '0) begin
            cnt_d[t] = cnt_q[t] - DLY_W'(1);
          end else begin
            q_d[t]     = mode_q[t] ? ab : hold_q[t];
            done_d[t]  = 1'b1;
            state_d[t] = S_IDLE;
          end
        end
        default: state_d[t] = S_IDLE;
      endcase
    end
  end

  // State, counters and outputs; reset drops any pending request without committing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TGT; t++) begin
        state_q[t] <= S_IDLE;
        cnt_q[t]   <= '0;
      end
      mode_q <= '0;
      hold_q <= '0;
      q      <= '0;
      done   <= '0;
    end else begin
      for (int t = 0; t < N_TGT; t++) begin
        state_q[t] <= state_d[t];
        cnt_q[t]   <= cnt_d[t];
      end
      mode_q <= mode_d;
      hold_q <= hold_d;
      q      <= q_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_sched_assign_ctrl.sv
// Bench for sched_assign_ctrl: deadline-based reference model plus directed scenarios.
// Inputs change just after the falling edge; outputs are compared later in the low phase.
// The model treats each slot as a pending deadline rather than a down-counter.
module tb_sched_assign_ctrl;
  localparam int N_TGT = 4;
  localparam int DLY_W = 6;
  localparam int TGT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [TGT_W-1:0] req_tgt = '0;
  logic [DLY_W-1:0] req_dly = '0;
  logic             req_mode = 1'b0;
  logic             flush = 1'b0;
  logic [N_TGT-1:0] q, busy, done;

  sched_assign_ctrl #(.N_TGT(N_TGT), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .req_valid(req_valid), .req_ready(req_ready), .req_tgt(req_tgt),
    .req_dly(req_dly), .req_mode(req_mode), .flush(flush),
    .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each pending slot holds an absolute commit edge.
  int               edge_n = 0;
  int               due [N_TGT];
  logic [N_TGT-1:0] pend = '0;
  logic [N_TGT-1:0] mmode = '0;
  logic [N_TGT-1:0] held = '0;
  logic [N_TGT-1:0] m_q = '0;
  logic [N_TGT-1:0] m_done = '0;
  logic             m_acc;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend   = '0;
        m_q    = '0;
        m_done = '0;
      end else begin
        m_acc  = req_valid && !pend[req_tgt] && !flush;
        edge_n++;
        m_done = '0;
        if (flush) begin
          pend = '0;
        end else begin
          for (int t = 0; t < N_TGT; t++) begin
            if (pend[t] && due[t] == edge_n) begin
              m_q[t]    = mmode[t] ? (a | b) : held[t];
              m_done[t] = 1'b1;
              pend[t]   = 1'b0;
            end
          end
        end
        if (m_acc) begin
          pend[req_tgt]  = 1'b1;
          due[req_tgt]   = edge_n + 1 + int'(req_dly);
          mmode[req_tgt] = req_mode;
          held[req_tgt]  = a | b;
        end
      end
    end
  end

  // Compare process: every cycle, well after the inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        check("q", 32'(q), 32'(m_q));
        check("busy", 32'(busy), 32'(pend));
        check("done", 32'(done), 32'(m_done));
        check("req_ready", 32'(req_ready), 32'(!pend[req_tgt]));
      end
    end
  end

  // Wait until the falling edge after model edge e, then step 1 time unit into the low phase.
  task automatic at_edge(input int e);
    int guard;
    guard = 0;
    while (edge_n < e && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != e) begin
      n_cmp++;
      n_err++;
      $display("FAIL edge_align: at edge %0d expected edge %0d", edge_n, e);
    end
    #1;
  endtask

  task automatic do_req(input int tgt, input int dly, input logic mode, output int k);
    req_tgt   = TGT_W'(tgt);
    req_dly   = DLY_W'(dly);
    req_mode  = mode;
    req_valid = 1'b1;
    k = edge_n + 1;
    at_edge(k);
    req_valid = 1'b0;
  endtask

  initial begin
    int k;
    int k3;
    int seen;
    repeat (3) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h1);

    // Mode 0: operands captured at accept; a later drop of a has no effect.
    a = 1'b1; b = 1'b0;
    do_req(1, 24, 1'b0, k);
    check("m0_busy_rise", 32'(busy[1]), 32'h1);
    at_edge(k + 8);
    a = 1'b0;
    at_edge(k + 24);
    check("m0_q_before", 32'(q[1]), 32'h0);
    check("m0_busy_hold", 32'(busy[1]), 32'h1);
    at_edge(k + 25);
    check("m0_q_commit", 32'(q[1]), 32'h1);
    check("m0_done", 32'(done[1]), 32'h1);
    check("m0_busy_fall", 32'(busy[1]), 32'h0);
    at_edge(k + 26);
    check("m0_done_once", 32'(done[1]), 32'h0);
    check("m0_q_keep", 32'(q[1]), 32'h1);

    // Mode 1: operands sampled at expiry, when a|b has dropped to 0.
    a = 1'b1;
    do_req(0, 18, 1'b1, k);
    at_edge(k + 8);
    a = 1'b0;
    at_edge(k + 18);
    check("m1_busy_hold", 32'(busy[0]), 32'h1);
    at_edge(k + 19);
    check("m1_q", 32'(q[0]), 32'h0);
    check("m1_done", 32'(done[0]), 32'h1);
    check("m1_busy_fall", 32'(busy[0]), 32'h0);

    // Simultaneous commits on tgt 2 and 3, then a request held off by a busy target.
    a = 1'b1;
    do_req(2, 5, 1'b0, k);
    do_req(3, 4, 1'b0, k3);
    req_tgt = 2'd2; req_dly = 6'd2; req_mode = 1'b0; req_valid = 1'b1;
    at_edge(k + 5);
    check("hold_off_ready", 32'(req_ready), 32'h0);
    at_edge(k + 6);
    check("sim_q", 32'(q[3:2]), 32'h3);
    check("sim_done", 32'(done[3:2]), 32'h3);
    check("sim_busy", 32'(busy[3:2]), 32'h0);
    check("rearm_ready", 32'(req_ready), 32'h1);
    at_edge(k + 7);
    check("rearm_accept", 32'(busy[2]), 32'h1);
    req_valid = 1'b0;
    a = 1'b0;
    at_edge(k + 10);
    check("rearm_q", 32'(q[2]), 32'h1);
    check("rearm_done", 32'(done[2]), 32'h1);

    // Flush cancels tgt 0 and wins over a same-cycle request to tgt 1.
    a = 1'b1;
    do_req(0, 10, 1'b0, k);
    at_edge(k + 3);
    flush = 1'b1;
    req_tgt = 2'd1; req_dly = 6'd2; req_mode = 1'b0; req_valid = 1'b1;
    at_edge(k + 4);
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_done", 32'(done), 32'h0);
    check("flush_q0", 32'(q[0]), 32'h0);
    at_edge(k + 11);
    check("flush_no_commit_q", 32'(q[0]), 32'h0);
    check("flush_no_commit_done", 32'(done), 32'h0);

    // Mode 1 with a|b rising between accept and expiry.
    a = 1'b0; b = 1'b0;
    do_req(0, 3, 1'b1, k);
    at_edge(k + 2);
    b = 1'b1;
    at_edge(k + 4);
    check("m1_rise_q", 32'(q[0]), 32'h1);
    check("m1_rise_done", 32'(done[0]), 32'h1);
    b = 1'b0;

    // Asynchronous reset in the middle of a long wait.
    a = 1'b1;
    do_req(3, 30, 1'b0, k);
    at_edge(k + 11);
    check("pre_rst_q", 32'(q), 32'hF);
    check("pre_rst_busy", 32'(busy), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != '0) seen++;
    end
    check("no_late_done", 32'(seen), 32'h0);
    check("no_late_q", 32'(q), 32'h0);

    // Delay boundaries: zero and the maximum 63.
    a = 1'b1; b = 1'b0;
    do_req(1, 0, 1'b0, k);
    check("dly0_busy", 32'(busy[1]), 32'h1);
    at_edge(k + 1);
    check("dly0_q", 32'(q[1]), 32'h1);
    check("dly0_done", 32'(done[1]), 32'h1);
    check("dly0_busy_fall", 32'(busy[1]), 32'h0);
    a = 1'b0; b = 1'b1;
    do_req(2, 63, 1'b1, k);
    at_edge(k + 63);
    check("dly63_busy", 32'(busy[2]), 32'h1);
    check("dly63_q_before", 32'(q[2]), 32'h0);
    at_edge(k + 64);
    check("dly63_q", 32'(q[2]), 32'h1);
    check("dly63_done", 32'(done[2]), 32'h1);
    check("dly63_busy_fall", 32'(busy[2]), 32'h0);

    repeat (3) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
